// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit.
// Five-state FSM (FETCH/DECODE/EXEC/MEM/WB) with combinational control
// outputs and a retired-instruction counter. Reset is asynchronous active-low
// and also masks every strobe/request output while asserted.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        IMAck,
    input  logic        DMAck,
    output logic        IMReq,
    output logic        DMReq,
    output logic        IRWE,
    output logic        PCWE,
    output logic        RegWE,
    output logic        DMWE,
    output logic [1:0]  PCSel,
    output logic [1:0]  RegA3Sel,
    output logic [1:0]  DatatoReg,
    output logic        ALUBSel,
    output logic [1:0]  EXTCtrl,
    output logic [2:0]  ALUOp,
    output logic [1:0]  SLCtrl,
    output logic [2:0]  State,
    output logic        Illegal,
    output logic [31:0] Retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        EXEC   = 3'b010,
        MEM    = 3'b011,
        WB     = 3'b100
    } state_t;

    state_t state, next;
    logic   retire;

    // Instruction decode (IR is stable from DECODE onward)
    logic is_r, addu, subu, sll, jr, jalr;
    logic ori, lw, sw, beq, lui, j, jal, sh, sb;
    logic is_jump, is_mem, is_store, legal;

    assign is_r     = (Opcode == 6'b000000);
    assign addu     = is_r && (Funct == 6'b100001);
    assign subu     = is_r && (Funct == 6'b100011);
    assign sll      = is_r && (Funct == 6'b000000);
    assign jr       = is_r && (Funct == 6'b001000);
    assign jalr     = is_r && (Funct == 6'b001001);
    assign ori      = (Opcode == 6'b001101);
    assign lw       = (Opcode == 6'b100011);
    assign sw       = (Opcode == 6'b101011);
    assign beq      = (Opcode == 6'b000100);
    assign lui      = (Opcode == 6'b001111);
    assign j        = (Opcode == 6'b000010);
    assign jal      = (Opcode == 6'b000011);
    assign sh       = (Opcode == 6'b101001);
    assign sb       = (Opcode == 6'b101000);
    assign is_jump  = j | jal | jr | jalr;
    assign is_store = sw | sh | sb;
    assign is_mem   = lw | is_store;
    assign legal    = addu | subu | sll | jr | jalr | ori | lw | sw | beq |
                      lui | j | jal | sh | sb;

    assign State = state;

    // ALU controls derived purely from the opcode, so they stay constant
    // across EXEC, MEM and WB of one instruction
    logic [2:0] alu_op;
    logic       alu_bsel;
    logic [1:0] alu_ext;

    // ALU control decode
    always_comb begin
        alu_op   = 3'b000;
        alu_bsel = 1'b0;
        alu_ext  = 2'b00;
        if (subu)          alu_op = 3'b001;
        else if (sll)      alu_op = 3'b011;
        else if (beq) begin
            alu_op  = 3'b100;
            alu_ext = 2'b01;
        end else if (ori | lui) begin
            alu_op   = 3'b010;
            alu_bsel = 1'b1;
            alu_ext  = lui ? 2'b10 : 2'b00;
        end else if (is_mem) begin
            alu_bsel = 1'b1;
            alu_ext  = 2'b01;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next;
    end

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      Retired <= '0;
        else if (retire) Retired <= Retired + 32'd1;
    end

    // Next-state and control outputs; reset low masks every output
    always_comb begin
        next      = state;
        retire    = 1'b0;
        IMReq     = 1'b0;
        DMReq     = 1'b0;
        IRWE      = 1'b0;
        PCWE      = 1'b0;
        RegWE     = 1'b0;
        DMWE      = 1'b0;
        PCSel     = 2'b00;
        RegA3Sel  = 2'b00;
        DatatoReg = 2'b00;
        ALUBSel   = 1'b0;
        EXTCtrl   = 2'b00;
        ALUOp     = 3'b000;
        SLCtrl    = 2'b00;
        Illegal   = 1'b0;

        if (state == EXEC || state == MEM || state == WB) begin
            ALUOp   = alu_op;
            ALUBSel = alu_bsel;
            EXTCtrl = alu_ext;
        end

        case (state)
            FETCH: begin
                IMReq = 1'b1;
                if (IMAck) begin
                    IRWE = 1'b1;
                    PCWE = 1'b1;
                    next = DECODE;
                end
            end
            DECODE: begin
                if (!legal) begin
                    Illegal = 1'b1;
                    next    = FETCH;
                end else if (is_jump) begin
                    PCWE   = 1'b1;
                    PCSel  = (j | jal) ? 2'b10 : 2'b11;
                    if (jal | jalr) begin
                        RegWE     = 1'b1;
                        RegA3Sel  = jal ? 2'b10 : 2'b00;
                        DatatoReg = 2'b10;
                    end
                    next   = FETCH;
                    retire = 1'b1;
                end else begin
                    next = EXEC;
                end
            end
            EXEC: begin
                if (beq) begin
                    PCWE   = Zero;
                    PCSel  = 2'b01;
                    next   = FETCH;
                    retire = 1'b1;
                end else if (is_mem) begin
                    next = MEM;
                end else begin
                    next = WB;
                end
            end
            MEM: begin
                DMReq  = 1'b1;
                DMWE   = is_store;
                SLCtrl = sh ? 2'b01 : (sb ? 2'b10 : 2'b00);
                if (DMAck) begin
                    next   = is_store ? FETCH : WB;
                    retire = is_store;
                end
            end
            WB: begin
                RegWE     = 1'b1;
                RegA3Sel  = is_r ? 2'b00 : 2'b01;
                DatatoReg = lw ? 2'b01 : 2'b00;
                next      = FETCH;
                retire    = 1'b1;
            end
            default: next = FETCH;
        endcase

        if (!reset) begin
            IMReq   = 1'b0;
            DMReq   = 1'b0;
            IRWE    = 1'b0;
            PCWE    = 1'b0;
            RegWE   = 1'b0;
            DMWE    = 1'b0;
            Illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver expands each instruction
// into its expected per-cycle control vector; a negedge monitor compares.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  Opcode = '0, Funct = '0;
    logic        Zero = 1'b0, IMAck = 1'b0, DMAck = 1'b0;
    logic        IMReq, DMReq, IRWE, PCWE, RegWE, DMWE, ALUBSel, Illegal;
    logic [1:0]  PCSel, RegA3Sel, DatatoReg, EXTCtrl, SLCtrl;
    logic [2:0]  ALUOp, State;
    logic [31:0] Retired;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .IMAck(IMAck), .DMAck(DMAck), .IMReq(IMReq), .DMReq(DMReq),
        .IRWE(IRWE), .PCWE(PCWE), .RegWE(RegWE), .DMWE(DMWE), .PCSel(PCSel),
        .RegA3Sel(RegA3Sel), .DatatoReg(DatatoReg), .ALUBSel(ALUBSel),
        .EXTCtrl(EXTCtrl), .ALUOp(ALUOp), .SLCtrl(SLCtrl), .State(State),
        .Illegal(Illegal), .Retired(Retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imreq, dmreq, irwe, pcwe, regwe, dmwe, ill;
        logic [1:0] pcsel, a3, dtr;
        logic       bsel;
        logic [1:0] ext;
        logic [2:0] aop;
        logic [1:0] sl;
    } vec_t;

    typedef struct packed {
        vec_t        e;
        vec_t        m;
        logic [31:0] ret;
    } item_t;

    item_t       sbq[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [31:0] ret_model = '0;

    // opcode/funct pairs of every supported instruction
    logic [11:0] tbl [14] = '{
        {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h00}, {6'h00, 6'h08},
        {6'h00, 6'h09}, {6'h0D, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00},
        {6'h04, 6'h00}, {6'h0F, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00},
        {6'h29, 6'h00}, {6'h28, 6'h00}
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Mask with state and all single-bit strobes always compared
    function automatic vec_t base_mask();
        vec_t m;
        m = '0;
        m.st = 3'b111;
        {m.imreq, m.dmreq, m.irwe, m.pcwe, m.regwe, m.dmwe, m.ill} = 7'h7F;
        return m;
    endfunction

    // Drive one cycle of inputs and queue the expected outputs for it
    task automatic cyc(input vec_t e, input vec_t m, input logic [5:0] op,
                       input logic [5:0] fn, input logic ia, input logic da,
                       input logic z);
        Opcode = op; Funct = fn; IMAck = ia; DMAck = da; Zero = z;
        sbq.push_back({e, m, ret_model});
        @(posedge clk); #1;
    endtask

    // Reference model: expand one instruction into its expected cycles
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input int fw, input int md, input logic z);
        vec_t e, m, ae, am;
        bit rt, addu, subu, sll, jr, jalr, ori, lw, sw, beq, lui, j, jal, sh, sb;
        bit legal, store, memop;
        rt   = (op == 6'h00);
        addu = rt && fn == 6'h21; subu = rt && fn == 6'h23; sll = rt && fn == 6'h00;
        jr   = rt && fn == 6'h08; jalr = rt && fn == 6'h09;
        ori  = op == 6'h0D; lw = op == 6'h23; sw = op == 6'h2B; beq = op == 6'h04;
        lui  = op == 6'h0F; j = op == 6'h02; jal = op == 6'h03;
        sh   = op == 6'h29; sb = op == 6'h28;
        store = sw | sh | sb;
        memop = store | lw;
        legal = addu | subu | sll | jr | jalr | ori | lw | store | beq | lui | j | jal;

        ae = '0; am = '0;
        if (addu | subu | sll) begin
            ae.aop = addu ? 3'd0 : (subu ? 3'd1 : 3'd3); ae.bsel = 1'b0;
            am.aop = '1; am.bsel = 1'b1;
        end else if (ori | lui) begin
            ae.aop = 3'd2; ae.bsel = 1'b1; ae.ext = lui ? 2'd2 : 2'd0;
            am.aop = '1; am.bsel = 1'b1; am.ext = '1;
        end else if (memop) begin
            ae.aop = 3'd0; ae.bsel = 1'b1; ae.ext = 2'd1;
            am.aop = '1; am.bsel = 1'b1; am.ext = '1;
        end else if (beq) begin
            ae.aop = 3'd4; ae.ext = 2'd1;
            am.aop = '1; am.ext = '1;
        end

        // FETCH: wait cycles then the acknowledged cycle
        for (int i = 0; i <= fw; i++) begin
            e = '0; m = base_mask();
            e.imreq = 1'b1;
            if (i == fw) begin
                e.irwe = 1'b1; e.pcwe = 1'b1; e.pcsel = 2'd0; m.pcsel = '1;
            end
            cyc(e, m, 6'($urandom), 6'($urandom), i == fw, 1'($urandom), 1'($urandom));
        end

        // DECODE
        e = '0; m = base_mask(); e.st = 3'd1;
        if (!legal) e.ill = 1'b1;
        else if (j | jal) begin e.pcwe = 1'b1; e.pcsel = 2'd2; m.pcsel = '1; end
        else if (jr | jalr) begin e.pcwe = 1'b1; e.pcsel = 2'd3; m.pcsel = '1; end
        if (jal | jalr) begin
            e.regwe = 1'b1; e.a3 = jal ? 2'd2 : 2'd0; e.dtr = 2'd2;
            m.a3 = '1; m.dtr = '1;
        end
        cyc(e, m, op, fn, 1'($urandom), 1'($urandom), 1'($urandom));

        if (legal && !(j | jal | jr | jalr)) begin
            // EXEC
            e = ae; m = base_mask() | am; e.st = 3'd2;
            if (beq) begin e.pcwe = z; e.pcsel = 2'd1; m.pcsel = '1; end
            cyc(e, m, op, fn, 1'($urandom), 1'($urandom), z);
            // MEM
            if (memop) begin
                for (int i = 0; i <= md; i++) begin
                    e = ae; m = base_mask() | am; e.st = 3'd3;
                    e.dmreq = 1'b1; e.dmwe = store;
                    e.sl = sh ? 2'd1 : (sb ? 2'd2 : 2'd0); m.sl = '1;
                    cyc(e, m, op, fn, 1'($urandom), i == md, 1'($urandom));
                end
            end
            // WB
            if (!beq && !store) begin
                e = ae; m = base_mask() | am; e.st = 3'd4;
                e.regwe = 1'b1; e.a3 = rt ? 2'd0 : 2'd1; e.dtr = lw ? 2'd1 : 2'd0;
                m.a3 = '1; m.dtr = '1;
                cyc(e, m, op, fn, 1'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        if (legal) ret_model = ret_model + 32'd1;
    endtask

    // Monitor: every cycle pops one expected vector and compares
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry");
            end else begin
                item_t it;
                vec_t  act;
                it  = sbq.pop_front();
                act = {State, IMReq, DMReq, IRWE, PCWE, RegWE, DMWE, Illegal,
                       PCSel, RegA3Sel, DatatoReg, ALUBSel, EXTCtrl, ALUOp, SLCtrl};
                tests++;
                if ((act & it.m) != (it.e & it.m)) begin
                    fails++;
                    $display("FAIL cycle_outputs: got %h expected %h (mask %h) at %0t",
                             act, it.e, it.m, $time);
                end
                tests++;
                if (Retired !== it.ret) begin
                    fails++;
                    $display("FAIL retired: got %0d expected %0d at %0t", Retired, it.ret, $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op, fn;
        int k;
        // Reset held low with a fetch ack present: outputs must stay quiet
        Opcode = 6'h00; Funct = 6'h21; IMAck = 1'b1;
        #3;
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_retired", Retired, 32'd0);
        chk("reset_strobes", 32'({IMReq, IRWE, PCWE, RegWE, DMReq, DMWE, Illegal}), 32'd0);
        @(negedge clk); @(negedge clk);
        chk("reset_hold_state", 32'(State), 32'd0);
        chk("reset_hold_imreq", 32'(IMReq), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        mon_en = 1'b1;

        // Directed: ADDU, LW with late DMAck, BEQ taken/not, JAL, illegal
        issue(6'h00, 6'h21, 0, 0, 1'b0);
        issue(6'h23, 6'h00, 1, 3, 1'b0);
        issue(6'h04, 6'h00, 0, 0, 1'b1);
        issue(6'h04, 6'h00, 0, 0, 1'b0);
        issue(6'h03, 6'h00, 0, 0, 1'b0);
        issue(6'h3F, 6'h00, 0, 0, 1'b0);
        issue(6'h00, 6'h3F, 0, 0, 1'b0);

        // Random instruction stream, including illegal encodings
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 19);
            if (k < 14) begin
                op = tbl[k][11:6];
                fn = (op == 6'h00) ? tbl[k][5:0] : 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            issue(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
        end
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        // Asynchronous reset in the middle of a SW memory phase
        Opcode = 6'h2B; Funct = 6'h00; IMAck = 1'b1; DMAck = 1'b0;
        @(posedge clk); #1; IMAck = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sw_mem_state", 32'(State), 32'd3);
        chk("sw_mem_dmwe", 32'(DMWE), 32'd1);
        chk("sw_retired_before", Retired, ret_model);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_dmwe", 32'(DMWE), 32'd0);
        chk("async_rst_dmreq", 32'(DMReq), 32'd0);
        chk("async_rst_state", 32'(State), 32'd0);
        chk("async_rst_retired", Retired, 32'd0);
        chk("async_rst_imreq", 32'(IMReq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
